// File: rtl/gal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gal_pkg : shared types and constants for the GAL OLMC bank                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gal_pkg;

  localparam int GAL_CFG_BITS_PER_CELL = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  typedef struct packed {
    logic reg_en;
    logic inv;
  } olmc_cfg_t;

endpackage
`default_nettype wire

// File: rtl/gal_olmc_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gal_olmc_cell : one output logic macrocell (Q flop, output XOR, feedback)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gal_olmc_cell
  import gal_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      a_i,
  input  olmc_cfg_t cfg_i,
  output logic      y_o,
  output logic      fb_o
);

  logic q_q;

  // Q captures every cycle so switching to registered mode shows last-cycle A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= a_i;
  end

  assign fb_o = cfg_i.reg_en ? q_q : a_i;
  assign y_o  = fb_o ^ cfg_i.inv;

endmodule
`default_nettype wire

// File: rtl/gal_olmc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gal_olmc_bank : N GAL macrocells with serial, parity-checked mode config.   |
// | Optional readback on CFG_SO when GAL_OLMC_READBACK_EN is defined.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gal_olmc_bank
  import gal_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(2*N+2)
) (
  input  logic         C,
  input  logic         R,
  input  logic [N-1:0] A,
  input  logic [N-1:0] E,
  output logic [N-1:0] Y,
  output logic [N-1:0] OE,
  output logic [N-1:0] FB,
  input  logic         CFG_START,
  input  logic         CFG_VALID,
  input  logic         CFG_BIT,
  output logic         CFG_BUSY,
  output logic         CFG_DONE,
  output logic         CFG_ERR,
  output logic         CFG_SO
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAL_CFG_BITS_PER_CELL * N);

  cfg_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_q, par_d;
  olmc_cfg_t [N-1:0]      shadow_q, shadow_d;
  olmc_cfg_t [N-1:0]      active_q, active_d;

  logic                   w_restart;
  logic                   w_take;
  logic [CNT_W-1:0]       w_idx;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    // A restart takes a same-cycle valid bit as bit 0 of the new frame.
    w_restart = CFG_START && ((state_q == SHIFT) || (state_q == CHECK));
    w_idx     = w_restart ? '0 : cnt_q;
    w_take    = CFG_VALID && (w_restart || (state_q == SHIFT));
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    if (w_take) begin
      for (int i = 0; i < N; i++) begin
        if (w_idx == CNT_W'(GAL_CFG_BITS_PER_CELL * i))     shadow_d[i].reg_en = CFG_BIT;
        if (w_idx == CNT_W'(GAL_CFG_BITS_PER_CELL * i + 1)) shadow_d[i].inv    = CFG_BIT;
      end
    end
    case (state_q)
      IDLE: begin
        if (CFG_START) begin
          state_d = SHIFT;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      SHIFT, CHECK: begin
        if (w_restart || w_take) begin
          cnt_d = w_idx + CNT_W'(w_take);
          par_d = (w_restart ? 1'b0 : par_q) ^ (w_take & CFG_BIT);
        end
        if (w_restart)                        state_d = SHIFT;
        else if (state_q == SHIFT) begin
          if (w_take && (cnt_q == LAST))      state_d = CHECK;
        end else                              state_d = par_q ? COMMIT : IDLE;
      end
      COMMIT: begin
        active_d = shadow_q;
        cnt_d    = '0;
        par_d    = 1'b0;
        state_d  = CFG_START ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CFG_BUSY = (state_q != IDLE);
    CFG_DONE = (state_q == COMMIT);
    CFG_ERR  = (state_q == CHECK) && !par_q && !CFG_START;
  end

`ifdef GAL_OLMC_READBACK_EN
  logic [CNT_W-1:0] rb_ptr_q;
  logic             w_rb_bit;
  logic             w_rb_shift;

  assign w_rb_shift = (state_q == IDLE) && CFG_VALID;

  always_ff @(posedge C or posedge R) begin
    if (R)                 rb_ptr_q <= '0;
    else if (CFG_START)    rb_ptr_q <= '0;
    else if (w_rb_shift)   rb_ptr_q <= (rb_ptr_q == LAST) ? '0 : rb_ptr_q + 1'b1;
  end

  // Final slot carries generated parity so the stream has odd weight.
  always_comb begin
    w_rb_bit = ~(^active_q);
    for (int i = 0; i < N; i++) begin
      if (rb_ptr_q == CNT_W'(GAL_CFG_BITS_PER_CELL * i))     w_rb_bit = active_q[i].reg_en;
      if (rb_ptr_q == CNT_W'(GAL_CFG_BITS_PER_CELL * i + 1)) w_rb_bit = active_q[i].inv;
    end
  end

  assign CFG_SO = w_rb_shift & w_rb_bit;
`else
  assign CFG_SO = 1'b0;
`endif

  assign OE = E;

  for (genvar g = 0; g < N; g++) begin : g_cell
    gal_olmc_cell u_cell (
      .clk_i (C),
      .rst_i (R),
      .a_i   (A[g]),
      .cfg_i (active_q[g]),
      .y_o   (Y[g]),
      .fb_o  (FB[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_gal_olmc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gal_olmc_bank : directed bench with a frame-level model of the bank      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gal_olmc_bank;

  localparam int N = 8;

  logic         C, R;
  logic [N-1:0] A, E, Y, OE, FB;
  logic         CFG_START, CFG_VALID, CFG_BIT;
  logic         CFG_BUSY, CFG_DONE, CFG_ERR, CFG_SO;

  gal_olmc_bank #(.N(N)) dut (
    .C(C), .R(R), .A(A), .E(E), .Y(Y), .OE(OE), .FB(FB),
    .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_BIT(CFG_BIT),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .CFG_SO(CFG_SO)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int           n_vec  = 0;
  int           n_fail = 0;
  logic         chk_en = 1'b0;
  logic         rnd    = 1'b0;
  logic [N-1:0] m_reg  = '0;
  logic [N-1:0] m_inv  = '0;
  logic [N-1:0] a_prev;
  logic         exp_busy, exp_done, exp_err, exp_so;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  always @(posedge C or posedge R) begin
    if (R) a_prev <= '0;
    else   a_prev <= A;
  end

  // Registered cells show last-cycle A, combinational cells current A; INV flips Y only.
  always @(negedge C) begin
    if (chk_en) begin
      logic [N-1:0] efb;
      for (int i = 0; i < N; i++) efb[i] = m_reg[i] ? a_prev[i] : A[i];
      chk("Y", 32'(Y), 32'(efb ^ m_inv));
      chk("FB", 32'(FB), 32'(efb));
      chk("OE", 32'(OE), 32'(E));
      chk("BUSY", 32'(CFG_BUSY), 32'(exp_busy));
      chk("DONE", 32'(CFG_DONE), 32'(exp_done));
      chk("ERR", 32'(CFG_ERR), 32'(exp_err));
      chk("SO", 32'(CFG_SO), 32'(exp_so));
    end
  end

  task automatic drive(input logic st, input logic vl, input logic bt,
                       input logic eb, input logic ed, input logic ee);
    @(posedge C); #1;
    CFG_START = st; CFG_VALID = vl; CFG_BIT = bt;
    exp_busy = eb; exp_done = ed; exp_err = ee; exp_so = 1'b0;
    if (rnd) begin
      A = N'($urandom);
      E = N'($urandom);
    end
  endtask

  function automatic logic [2*N:0] make_frame(input logic [N-1:0] rv, input logic [N-1:0] iv,
                                              input logic flip);
    logic [2*N:0] b;
    for (int i = 0; i < N; i++) begin
      b[2*i]   = rv[i];
      b[2*i+1] = iv[i];
    end
    b[2*N] = ~(^b[2*N-1:0]) ^ flip;
    return b;
  endfunction

  task automatic send_frame(input logic [N-1:0] rv, input logic [N-1:0] iv, input logic flip,
                            input logic in_shift, input int stall_at);
    logic [2*N:0] b;
    logic         ok;
    b  = make_frame(rv, iv, flip);
    ok = ($countones(b) % 2) == 1;
    if (in_shift) drive(1'b1, 1'b1, b[0], 1'b1, 1'b0, 1'b0);
    else          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = in_shift ? 1 : 0; k <= 2*N; k++) begin
      if (k == stall_at) repeat (3) drive(1'b0, 1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, b[k], 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, !ok);
    if (ok) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ok) begin
      m_reg = rv;
      m_inv = iv;
    end
  endtask

  task automatic partial(input int nbits);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < nbits; k++) drive(1'b0, 1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2*N:0] rb;
    R = 1'b1; A = 8'hA5; E = 8'hFF;
    CFG_START = 1'b0; CFG_VALID = 1'b0; CFG_BIT = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_so = 1'b0;
    chk_en = 1'b1;
    @(posedge C); #1 R = 1'b0;
    @(negedge C);
    chk("t1_y", 32'(Y), 32'h A5);
    chk("t1_fb", 32'(FB), 32'h A5);
    chk("t1_oe", 32'(OE), 32'h FF);
    chk("t1_cfg", 32'({CFG_BUSY, CFG_DONE, CFG_ERR, CFG_SO}), 32'h0);

    // All cells registered, with a mid-frame stall.
    rnd = 1'b1;
    send_frame(8'hFF, 8'h00, 1'b0, 1'b0, 5);
    rnd = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'h3C;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'hC3;
    @(negedge C);
    chk("t2_y", 32'(Y), 32'h3C);
    chk("t2_fb", 32'(FB), 32'h3C);

    // Even-weight frame is rejected; registered config stays.
    rnd = 1'b1;
    send_frame(8'h00, 8'h01, 1'b1, 1'b0, -1);
    rnd = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'h55;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'hAA;
    @(negedge C);
    chk("t3_y", 32'(Y), 32'h55);

    // Restart at bit 7; only the second frame lands.
    rnd = 1'b1;
    partial(7);
    send_frame(8'hF0, 8'h0F, 1'b0, 1'b1, -1);
    rnd = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); A = 8'hFF;
    @(negedge C);
    chk("t4_y", 32'(Y), 32'h00);
    chk("t4_fb", 32'(FB), 32'h0F);

    // Reset mid-frame at bit 10 clears everything.
    rnd = 1'b1;
    partial(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    R = 1'b1; m_reg = '0; m_inv = '0;
    rnd = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    R = 1'b0; A = 8'h5A;
    @(negedge C);
    chk("t5_y", 32'(Y), 32'h5A);
    chk("t5_fb", 32'(FB), 32'h5A);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_busy", 32'(CFG_BUSY), 32'h0);

    // Valid bits in IDLE never start a frame; with readback they stream the config.
    rnd = 1'b1;
    send_frame(8'h0F, 8'h00, 1'b0, 1'b0, -1);
    rb = make_frame(8'h0F, 8'h00, 1'b0);
    for (int k = 0; k < 2*N + 3; k++) begin
      drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
`ifdef GAL_OLMC_READBACK_EN
      exp_so = rb[k % (2*N + 1)];
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge C);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
